// File: rtl/ws2812_pkg.sv
// Shared constants and types for the WS2812 serializer and bit-writer stages.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ws2812_pkg;

  localparam int PIXEL_W          = 24;
  localparam int CLK_HZ           = 50_000_000;
  localparam int DEF_BIT_CYCLES   = 63;    // 1.26 us bit slot at 50 MHz
  localparam int DEF_LATCH_CYCLES = 2600;  // 52 us latch gap at 50 MHz

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } ser_state_t;

endpackage

// File: rtl/ws2812_pixel_serializer_if.sv
// Pixel handshake bus between the frame sequencer and the serializer.
// Latency: n/a (wiring only).
// Backpressure: valid/ready; data and last are qualified by valid && ready.
interface ws2812_pixel_serializer_if;

  logic [ws2812_pkg::PIXEL_W-1:0] pixel_data;
  logic                           pixel_last;
  logic                           pixel_valid;
  logic                           pixel_ready;

  modport master (
    output pixel_data,
    output pixel_last,
    output pixel_valid,
    input  pixel_ready
  );

  modport slave (
    input  pixel_data,
    input  pixel_last,
    input  pixel_valid,
    output pixel_ready
  );

endinterface

// File: rtl/ws2812_pixel_serializer.sv
// Serialises 24-bit GRB pixels MSB-first into per-bit levels for the WS2812 bit-writer.
// Latency: first bit on value the cycle after the handshake; each bit held BIT_CYCLES clocks.
// Backpressure: ready only in IDLE or the final cycle of a non-last pixel; never from valid.
module ws2812_pixel_serializer
  import ws2812_pkg::*;
#(
  parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic                            clk,
  input  logic                            rst,
  ws2812_pixel_serializer_if.slave        pix,
  output logic                            value,
  output logic                            wr_rst,
  output logic                            busy,
  output logic                            underrun
);

  // One counter serves both the bit slot and the latch gap, so it is sized
  // for the longer of the two (the latch gap).
  localparam int             CW         = $clog2(LATCH_CYCLES);
  localparam logic [CW-1:0]  BIT_LAST   = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0]  LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [4:0]     TOP_BIT    = 5'(PIXEL_W - 1);

  ser_state_t           state;
  logic [CW-1:0]        cyc_cnt;
  logic [4:0]           bit_cnt;
  logic [PIXEL_W-1:0]   sr;
  logic                 last_q;

  logic                 slot_end;
  logic                 pixel_end;
  logic                 take;

  // Slot/pixel boundary decode and the state-derived ready (no path from valid).
  always_comb begin
    slot_end        = (cyc_cnt == BIT_LAST);
    pixel_end       = (state == SHIFT) && slot_end && (bit_cnt == 5'd0);
    pix.pixel_ready = (state == IDLE) || (pixel_end && !last_q);
    take            = pix.pixel_ready && pix.pixel_valid;
    busy            = (state != IDLE);
  end

  // Serializer FSM; value and wr_rst are registered alongside the state so
  // they change only on clock edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LATCH;
      cyc_cnt  <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      last_q   <= 1'b0;
      value    <= 1'b0;
      wr_rst   <= 1'b1;
      underrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (take) begin
            sr      <= pix.pixel_data;
            last_q  <= pix.pixel_last;
            bit_cnt <= TOP_BIT;
            cyc_cnt <= '0;
            value   <= pix.pixel_data[PIXEL_W-1];
            wr_rst  <= 1'b0;
            state   <= SHIFT;
          end
        end

        SHIFT: begin
          if (!slot_end) begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end else begin
            cyc_cnt <= '0;
            if (bit_cnt != 5'd0) begin
              // Next bit of the same pixel.
              sr      <= sr << 1;
              value   <= sr[PIXEL_W-2];
              bit_cnt <= bit_cnt - 5'd1;
            end else if (take) begin
              // Seamless hand-over to the next pixel of the frame.
              sr      <= pix.pixel_data;
              last_q  <= pix.pixel_last;
              bit_cnt <= TOP_BIT;
              value   <= pix.pixel_data[PIXEL_W-1];
            end else begin
              // Frame ended, either cleanly or starved; latch what was sent.
              if (!last_q) begin
                underrun <= 1'b1;
              end
              value  <= 1'b0;
              wr_rst <= 1'b1;
              state  <= LATCH;
            end
          end
        end

        LATCH: begin
          if (cyc_cnt == LATCH_LAST) begin
            cyc_cnt <= '0;
            state   <= IDLE;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        default: begin
          cyc_cnt <= '0;
          value   <= 1'b0;
          wr_rst  <= 1'b1;
          state   <= LATCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_pixel_serializer.sv
// Scoreboard bench: drivers push expected bit/latch/idle events, monitors decode the line.
// Latency: n/a (testbench).
// Backpressure: drivers honour pixel_ready with bounded waits.
module tb_ws2812_pixel_serializer;
  import ws2812_pkg::*;

  localparam int BC  = DEF_BIT_CYCLES;
  localparam int LC  = DEF_LATCH_CYCLES;
  localparam int SBC = 4;
  localparam int SLC = 10;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_s = 1'b1;
  always #10 clk = ~clk;

  logic value, wr_rst, busy, underrun;
  logic value_s, wr_rst_s, busy_s, underrun_s;

  ws2812_pixel_serializer_if pif ();
  ws2812_pixel_serializer_if sif ();

  ws2812_pixel_serializer dut (
    .clk      (clk),
    .rst      (rst),
    .pix      (pif.slave),
    .value    (value),
    .wr_rst   (wr_rst),
    .busy     (busy),
    .underrun (underrun)
  );

  ws2812_pixel_serializer #(.BIT_CYCLES(SBC), .LATCH_CYCLES(SLC)) dut_s (
    .clk      (clk),
    .rst      (rst_s),
    .pix      (sif.slave),
    .value    (value_s),
    .wr_rst   (wr_rst_s),
    .busy     (busy_s),
    .underrun (underrun_s)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk1(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, req, $time);
    end
  endfunction

  function automatic void chki(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
    end
  endfunction

  // ---------------- reference model: expected line events ----------------
  typedef enum int {EV_BIT = 0, EV_LATCH = 1, EV_IDLE = 2} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    logic     bitv;
    logic     urun;
  } ev_t;

  ev_t  exp_q[$];
  logic urun_model = 1'b0;

  function automatic void push_ev(input ev_kind_t k, input logic b, input logic u);
    ev_t e;
    e.kind = k;
    e.bitv = b;
    e.urun = u;
    exp_q.push_back(e);
  endfunction

  // A pixel is 24 bit slots MSB first; a frame end adds one latch gap and an idle spell.
  function automatic void model_pixel(input logic [23:0] d, input logic ends, input logic starve);
    for (int i = 23; i >= 0; i--) push_ev(EV_BIT, d[i], 1'b0);
    if (starve) urun_model = 1'b1;
    if (ends) begin
      push_ev(EV_LATCH, 1'b0, urun_model);
      push_ev(EV_IDLE, 1'b0, 1'b0);
    end
  endfunction

  function automatic void emit(input ev_kind_t k, input logic b, input logic bad,
                               input logic u, input int len, input logic rdy);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d want none at %0t", int'(k), $time);
      return;
    end
    e = exp_q.pop_front();
    chki("event_kind", int'(k), int'(e.kind));
    if (k == e.kind) begin
      case (k)
        EV_BIT: begin
          chk1("bit_value", b, e.bitv);
          chk1("bit_stable", bad, 1'b0);
        end
        EV_LATCH: begin
          chki("latch_len", len, LC);
          chk1("latch_ready_low", rdy, 1'b0);
          chk1("latch_underrun", u, e.urun);
        end
        default: ;
      endcase
    end
  endfunction

  // ---------------- monitor: decode the main DUT's line ----------------
  int   mode, mode_prev, slot_cnt, latch_len;
  logic slot_val, slot_bad, latch_rdy, latch_u;

  initial begin
    mode_prev = 0;
    slot_cnt  = 0;
    latch_len = 0;
    slot_val  = 1'b0;
    slot_bad  = 1'b0;
    latch_rdy = 1'b0;
    latch_u   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mode_prev = 0;
        slot_cnt  = 0;
        latch_len = 0;
      end else begin
        mode = !wr_rst ? 1 : (busy ? 2 : 3);
        if (mode != mode_prev) begin
          if (mode_prev == 1) chki("partial_slot", slot_cnt, 0);
          if (mode_prev == 2) emit(EV_LATCH, 1'b0, 1'b0, latch_u, latch_len, latch_rdy);
          if (mode_prev == 3) emit(EV_IDLE, 1'b0, 1'b0, 1'b0, 0, 1'b0);
          if (mode == 2) begin
            latch_len = 0;
            latch_rdy = 1'b0;
            latch_u   = underrun;
          end
          if (mode == 3) chk1("ready_in_idle", pif.pixel_ready, 1'b1);
          slot_cnt = 0;
        end
        if (mode == 1) begin
          if (slot_cnt == 0) begin
            slot_val = value;
            slot_bad = 1'b0;
          end else if (value !== slot_val) begin
            slot_bad = 1'b1;
          end
          slot_cnt++;
          if (slot_cnt == BC) begin
            emit(EV_BIT, slot_val, slot_bad, 1'b0, 0, 1'b0);
            slot_cnt = 0;
          end
        end else if (mode == 2) begin
          latch_len++;
          if (pif.pixel_ready) latch_rdy = 1'b1;
        end
        mode_prev = mode;
      end
    end
  end

  // ---------------- driver for the main DUT ----------------
  task automatic send(input logic [23:0] d, input logic lst, input logic keep,
                      input logic starve, output logic pb);
    int   n;
    logic hs, last_busy;
    n = 0;
    hs = 1'b0;
    pb = 1'b0;
    last_busy = 1'b0;
    pif.pixel_data  = d;
    pif.pixel_last  = lst;
    pif.pixel_valid = 1'b1;
    while (!hs && n < 10000) begin
      @(negedge clk);
      pb = last_busy;
      last_busy = busy;
      hs = pif.pixel_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: no pixel_ready within %0d cycles", n);
      pif.pixel_valid = 1'b0;
      return;
    end
    model_pixel(d, lst || starve, starve);
    if (!keep) pif.pixel_valid = 1'b0;
    @(negedge clk);
    chk1("first_bit_wr_rst", wr_rst, 1'b0);
    chk1("first_bit_value", value, d[23]);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still %b after %0d cycles", busy, n);
    end
  endtask

  task automatic wait_latch();
    int n;
    n = 0;
    while (!(wr_rst === 1'b1 && busy === 1'b1) && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!(wr_rst === 1'b1 && busy === 1'b1)) begin
      checks++;
      errors++;
      $display("FAIL latch_timeout: no latch after %0d cycles", n);
    end
  endtask

  // ---------------- small-parameter build: per-cycle trace scoreboard ----------------
  logic [3:0] sq[$];   // {wr_rst, value, pixel_ready, busy}
  logic       small_done = 1'b0;

  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (!rst_s && sq.size() != 0) begin
        e = sq.pop_front();
        chki("small_trace", int'({wr_rst_s, value_s, sif.pixel_ready, busy_s}), int'(e));
      end
    end
  end

  initial begin
    logic [23:0] pat;
    int          n;
    logic        hs;
    sif.pixel_valid = 1'b0;
    sif.pixel_data  = '0;
    sif.pixel_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_s = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pat = (k == 0) ? 24'h800001 : 24'($urandom);
      sif.pixel_data  = pat;
      sif.pixel_last  = 1'b1;
      sif.pixel_valid = 1'b1;
      n = 0;
      hs = 1'b0;
      while (!hs && n < 1000) begin
        @(negedge clk);
        hs = sif.pixel_ready;
        @(posedge clk);
        #1;
        n++;
      end
      sif.pixel_valid = 1'b0;
      if (!hs) begin
        checks++;
        errors++;
        $display("FAIL small_handshake_timeout: no pixel_ready within %0d cycles", n);
      end else begin
        for (int i = 23; i >= 0; i--)
          for (int c = 0; c < SBC; c++) sq.push_back({1'b0, pat[i], 1'b0, 1'b1});
        for (int c = 0; c < SLC; c++) sq.push_back(4'b1001);
        sq.push_back(4'b1010);
      end
      n = 0;
      while (sq.size() != 0 && n < 500) begin
        @(posedge clk);
        n++;
      end
    end
    chk1("small_underrun", underrun_s, 1'b0);
    small_done = 1'b1;
  end

  // ---------------- main stimulus ----------------
  initial begin
    logic        pb;
    logic [23:0] d;
    int          npix, n;
    pif.pixel_valid = 1'b0;
    pif.pixel_data  = '0;
    pif.pixel_last  = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_wr_rst", wr_rst, 1'b1);
    chk1("rst_value", value, 1'b0);
    chk1("rst_ready", pif.pixel_ready, 1'b0);
    chk1("rst_busy", busy, 1'b1);
    chk1("rst_underrun", underrun, 1'b0);
    push_ev(EV_LATCH, 1'b0, 1'b0);
    push_ev(EV_IDLE, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single last pixel after the power-up latch.
    send(24'hFF0000, 1'b1, 1'b0, 1'b0, pb);
    wait_idle();

    // Back-to-back pair with valid held.
    send(24'hA5A5A5, 1'b0, 1'b1, 1'b0, pb);
    send(24'h5A5A5A, 1'b1, 1'b0, 1'b0, pb);
    wait_idle();
    chk1("b2b_underrun", underrun, 1'b0);

    // Starved frame.
    send(24'h00FF00, 1'b0, 1'b0, 1'b1, pb);
    wait_latch();

    // Offer during latch: held off, taken on the first IDLE cycle.
    send(24'h123456, 1'b1, 1'b0, 1'b0, pb);
    chk1("accept_first_idle", pb, 1'b1);
    wait_idle();

    // Random frames.
    for (int f = 0; f < 3; f++) begin
      npix = $urandom_range(1, 2);
      for (int p = 0; p < npix; p++) begin
        d = 24'($urandom);
        send(d, p == npix - 1, p != npix - 1, 1'b0, pb);
      end
      wait_idle();
    end

    // Reset during bit 10 of a pixel.
    send(24'($urandom), 1'b1, 1'b0, 1'b0, pb);
    repeat (13 * BC + 20) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    urun_model = 1'b0;
    push_ev(EV_LATCH, 1'b0, 1'b0);
    push_ev(EV_IDLE, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("midrst_wr_rst", wr_rst, 1'b1);
    chk1("midrst_value", value, 1'b0);
    chk1("midrst_busy", busy, 1'b1);
    chk1("midrst_underrun", underrun, 1'b0);
    chk1("midrst_ready", pif.pixel_ready, 1'b0);
    @(posedge clk);
    #1;

    // Recovery frame after reset.
    send(24'($urandom), 1'b1, 1'b0, 1'b0, pb);
    wait_idle();
    repeat (3) @(posedge clk);

    n = 0;
    while (!small_done && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk1("small_done", small_done, 1'b1);
    chki("small_drain", sq.size(), 0);
    chki("main_drain", exp_q.size(), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws2812_pixel_serializer.md
# ws2812_pixel_serializer

Upstream feeder for the WS2812 bit-writer stage (`write`). Accepts 24-bit GRB pixel words over a valid/ready handshake and serialises them MSB-first. Drives the bit-writer's `value` and `rst` inputs: `value` is held steady for one full bit period per bit, and the line is held in latch (`rst` high) for the ≥50 µs WS2812 reset gap between frames and after reset. Sits between the pixel frame buffer/sequencer and `write`, all in the 50 MHz domain.

## Interface
- `BIT_CYCLES`, default 63: clocks per WS2812 bit slot (1.26 µs at 50 MHz).
- `LATCH_CYCLES`, default 2600: clocks of latch/reset gap (52 µs at 50 MHz, above the 50 µs minimum).
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `pixel_data`  in  24  GRB word; bit 23 = G[7], transmitted first.
- `pixel_last`  in  1  qualifies `pixel_data`; this pixel ends the frame.
- `pixel_valid`  in  1  upstream offers a pixel.
- `pixel_ready`  out  1  block accepts the pixel this cycle.
- `value`  out  1  bit to transmit; feeds `write.value`.
- `wr_rst`  out  1  latch request; feeds `write.rst` (line low while high).
- `busy`  out  1  high whenever state ≠ IDLE.
- `underrun`  out  1  sticky; set when a frame starves mid-frame; cleared only by `rst`.

## Operation
- States: IDLE, SHIFT, LATCH.
- Counters:
  - `cyc_cnt`, $clog2(LATCH_CYCLES) bits, shared by SHIFT and LATCH.
  - `bit_cnt`, 5 bits, counts 23 down to 0.
  - 24-bit shift register `sr`.
  - `last_q` flag.
- Reset: enter LATCH with `cyc_cnt` = 0. The strip gets a full latch gap before the first pixel.
  - Reset outputs: `value` = 0, `wr_rst` = 1, `pixel_ready` = 0, `busy` = 1, `underrun` = 0.
- IDLE:
  - `wr_rst` = 1, `value` = 0, `pixel_ready` = 1.
  - On handshake: load `sr`, `last_q` ← `pixel_last`, `bit_cnt` ← 23, `cyc_cnt` ← 0, go to SHIFT.
- SHIFT:
  - `wr_rst` = 0, `value` = `sr[23]`.
  - `cyc_cnt` increments each clock. At `BIT_CYCLES-1` it wraps to 0, `sr` shifts left, and `bit_cnt` decrements.
- End of pixel: the cycle where `bit_cnt` = 0 and `cyc_cnt` = `BIT_CYCLES-1`.
  - If `last_q` = 0: `pixel_ready` = 1 in that cycle only.
    - Handshake: reload `sr`, `bit_cnt`, and `last_q`; stay in SHIFT. No gap between pixels.
    - No handshake: set `underrun`, go to LATCH. The partial frame is latched.
  - If `last_q` = 1: `pixel_ready` = 0; go to LATCH.
- LATCH:
  - `wr_rst` = 1, `value` = 0, `pixel_ready` = 0.
  - After `LATCH_CYCLES` clocks (`cyc_cnt` reaches `LATCH_CYCLES-1`), go to IDLE.
- `pixel_data` and `pixel_last` are ignored unless `pixel_valid` && `pixel_ready`.
- `rst` overrides everything, including mid-bit and mid-latch. The in-flight pixel is discarded.

## Timing
- Handshake at edge N: first bit appears on `value` (with `wr_rst` = 0) from cycle N+1.
- Each bit is held exactly `BIT_CYCLES` cycles. One pixel occupies 24·`BIT_CYCLES` = 1512 cycles.
- Back-to-back pixels: the next pixel's bit 23 follows the previous bit 0 with no idle cycle.
- Frame end: `wr_rst` rises the cycle after the last bit slot and stays high `LATCH_CYCLES` cycles. `pixel_ready` rises in the following cycle (IDLE).
- After `rst` deasserts: `pixel_ready` first rises `LATCH_CYCLES` cycles later.
- `pixel_ready` is registered-state-derived (no combinational path from `pixel_valid`).
- `value` and `wr_rst` are glitch-free registered outputs.

## Structure
- Shared package `ws2812_pkg`, holding:
  - `PIXEL_W` = 24
  - default `BIT_CYCLES` and `LATCH_CYCLES`
  - `CLK_HZ` = 50_000_000
  - state enum `ser_state_t` {IDLE, SHIFT, LATCH}
- The bit-writer stage reuses the package constants.
- Single module, no sub-module. The parent instantiates this block and `write` side by side.

## Test plan
- Single pixel 0xFF0000 with `pixel_last`=1 after the initial latch. Required response:
  - `value` = 1 for 504 cycles, then 0 for 1008, with `wr_rst` = 0 throughout.
  - Then `wr_rst` = 1 for 2600 cycles.
  - `pixel_ready` = 1 on the next cycle.
- Back-to-back 0xA5A5A5 then 0x5A5A5A(last), with valid held. Required response:
  - 48 bit slots of 63 cycles, pattern 1010_0101… then 0101_1010….
  - No extra cycle between the two pixels.
  - `underrun` stays 0.
- Underrun: one pixel 0x00FF00 (last=0), then valid low. Required response:
  - `underrun` = 1 and `wr_rst` = 1 starting the cycle after bit 0 ends.
  - LATCH lasts 2600 cycles.
- `pixel_valid` asserted with 0x123456 during LATCH. Required response:
  - Held off while `pixel_ready` = 0.
  - Accepted on the first IDLE cycle.
  - Bit 23 (0) appears the next cycle.
- `rst` pulsed during bit 10 of a pixel. Required response:
  - Next cycle: `wr_rst` = 1, `value` = 0, `busy` = 1, `underrun` = 0.
  - `pixel_ready` stays low 2600 cycles.
- `BIT_CYCLES`=4, `LATCH_CYCLES`=10 build, pixel 0x800001(last). Required response:
  - `value` 1 for 4 cycles, 0 for 88, 1 for 4.
  - Then latch for 10 cycles.
